// File: rtl/sd_pkg.sv
// Shared definitions for the SD front-end blocks.
//   sd_ser_state_t : serializer FSM state (idle, shifting data bits, idle gap bits)
//   SD_WORD_W_MAX  : widest word the serializer is meant to handle
//   SD_GAP_W       : width of the inter-word gap counter
package sd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } sd_ser_state_t;

  localparam int unsigned SD_WORD_W_MAX = 32;
  localparam int unsigned SD_GAP_W      = 4;

endpackage

// File: rtl/sd_bit_serializer_if.sv
// Handshake and serial-output bundle of sd_bit_serializer.
//   din/din_valid/din_ready : parallel word input, valid/ready handshake
//   x/x_valid/last          : serial bit stream toward the SD detector
//   busy                    : shifter or holding buffer occupied
// Modports: slave = serializer side, master = upstream source / observer side.
interface sd_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    input  x,
    input  x_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    output x,
    output x_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/sd_down_counter.sv
// Loadable terminal-count counter.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load; it is the number of enabled cycles until done
//   en         : count down by one; holds at 0 instead of wrapping
//   done       : count has reached its terminal value (0)
module sd_down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/sd_bit_serializer.sv
// Parallel-in, serial-out feeder for the SD sequence detector.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : slave view of sd_bit_serializer_if
//                (din/din_valid/din_ready in, x/x_valid/last/busy out)
// A one-word holding register lets a second word be accepted while the first
// shifts, so words stream back to back. GAP idle cycles follow every word.
module sd_bit_serializer
  import sd_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned GAP       = 0
) (
  input  logic               clk,
  input  logic               reset,
  sd_bit_serializer_if.slave bus
);

  localparam int unsigned BcntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BcntW-1:0]    BcntLoad = BcntW'(WIDTH - 1);
  localparam logic [SD_GAP_W-1:0] GcntLoad = (GAP > 0) ? SD_GAP_W'(GAP - 1) : '0;

  sd_ser_state_t    state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;

  logic bcnt_load, bcnt_en, bcnt_done;
  logic gcnt_load, gcnt_en, gcnt_done;
  logic shifter_free, xfer;

  // bcnt counts the bits remaining after the current one; done marks the last bit.
  sd_down_counter #(
    .W (BcntW)
  ) u_bcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (bcnt_load),
    .load_val (BcntLoad),
    .en       (bcnt_en),
    .done     (bcnt_done)
  );

  // gcnt counts the gap cycles remaining after the current one.
  sd_down_counter #(
    .W (SD_GAP_W)
  ) u_gcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gcnt_load),
    .load_val (GcntLoad),
    .en       (gcnt_en),
    .done     (gcnt_done)
  );

  assign bus.din_ready = !reset && !hold_full_q;
  assign xfer          = bus.din_valid && bus.din_ready;

  always_comb begin
    shifter_free = 1'b0;
    unique case (state_q)
      StIdle:  shifter_free = 1'b1;
      StShift: shifter_free = bcnt_done && (GAP == 0);
      StGap:   shifter_free = gcnt_done;
      default: shifter_free = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bcnt_load   = 1'b0;
    bcnt_en     = 1'b0;
    gcnt_load   = 1'b0;
    gcnt_en     = 1'b0;

    unique case (state_q)
      StShift: begin
        bcnt_en = 1'b1;
        sh_d    = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
        if (bcnt_done && (GAP > 0)) begin
          state_d   = StGap;
          gcnt_load = 1'b1;
        end
      end
      StGap: begin
        gcnt_en = 1'b1;
      end
      default: ;
    endcase

    // A pending held word always wins over the input; din_ready is low then,
    // so no transfer can coincide with the hold-to-shifter move.
    if (shifter_free) begin
      if (hold_full_q) begin
        sh_d        = hold_q;
        hold_full_d = 1'b0;
        state_d     = StShift;
        bcnt_load   = 1'b1;
      end else if (xfer) begin
        sh_d      = bus.din;
        state_d   = StShift;
        bcnt_load = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end else if (xfer) begin
      hold_d      = bus.din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  // Outputs decode registered state only; no input-to-output path except din_ready.
  assign bus.x       = (state_q == StShift) ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : 1'b0;
  assign bus.x_valid = (state_q == StShift);
  assign bus.last    = (state_q == StShift) && bcnt_done;
  assign bus.busy    = (state_q != StIdle) || hold_full_q;

endmodule
